// File: rtl/mm_pkg.sv
// mm_pkg: shared widths, drain FSM states and job-length helper for the result drain
package mm_pkg;
  localparam int MM_IN_W  = 1024;
  localparam int MM_OUT_W = 512;
  localparam int MM_CNT_W = 32;

  typedef enum logic [1:0] {IDLE, RUN, DONE} drain_state_t;

  function automatic logic [63:0] words_for(input logic [31:0] rows1, input logic [31:0] rows2);
    logic [63:0] p;
    p = {32'd0, rows1} * {32'd0, rows2};
    return (p + 64'd31) >> 5;
  endfunction
endpackage

// File: rtl/mm_drain_fifo.sv
// mm_drain_fifo: 2-entry register FIFO holding result words, head always in entry 0
module mm_drain_fifo #(
  parameter int W = 1024
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_din,
  output logic [1:0]   o_count,
  output logic [W-1:0] o_head
);
  logic [W-1:0] r_e0, r_e1;
  logic [1:0]   r_count;
  logic         w_widx;

  assign w_widx  = r_count[1] || (r_count[0] && !i_pop);
  assign o_count = r_count;
  assign o_head  = r_e0;

  // shift on pop, then write the new word into the first free slot after that shift
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_e0    <= '0;
      r_e1    <= '0;
      r_count <= '0;
    end else begin
      if (i_pop) r_e0 <= r_e1;
      if (i_push) begin
        if (w_widx) r_e1 <= i_din;
        else r_e0 <= i_din;
      end
      r_count <= r_count + {1'b0, i_push} - {1'b0, i_pop};
    end
  end
endmodule

// File: rtl/mm_result_drain.sv
// mm_result_drain: pulls 1024-bit result words and serializes them as 512-bit host lines
module mm_result_drain
  import mm_pkg::*;
#(
  parameter int IN_W  = MM_IN_W,
  parameter int OUT_W = MM_OUT_W,
  parameter int CNT_W = MM_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [63:0]      size1,
  input  logic [63:0]      size2,
  input  logic             empty,
  output logic             pull,
  input  logic [IN_W-1:0]  data_in,
  output logic [OUT_W-1:0] wr_data,
  output logic             wr_valid,
  input  logic             wr_ready,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] lines_out
);
  drain_state_t     r_state, w_next;
  logic [CNT_W-1:0] r_total, r_pulled, r_emitted, r_lines, w_total;
  logic             r_inflight, r_half;
  logic [1:0]       w_count;
  logic [IN_W-1:0]  w_head;
  logic             w_start_ok, w_accept, w_pop, w_last, w_unused;

  assign w_unused   = ^{size1[63:32], size2[63:32]};
  assign w_total    = CNT_W'(words_for(size1[31:0], size2[31:0]));
  assign w_start_ok = start && r_state != RUN;
  assign w_accept   = wr_valid && wr_ready;
  assign w_pop      = w_accept && r_half;
  assign w_last     = w_pop && r_emitted == r_total - CNT_W'(1);
  assign lines_out  = r_lines;

  mm_drain_fifo #(.W(IN_W)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (r_inflight),
    .i_pop   (w_pop),
    .i_din   (data_in),
    .o_count (w_count),
    .o_head  (w_head)
  );

  // next state plus pull gating and half-select output mux
  always_comb begin
    w_next   = (w_start_ok) ? ((w_total == '0) ? DONE : RUN) : (r_state == RUN && w_last) ? DONE : r_state;
    pull     = r_state == RUN && !empty && r_pulled < r_total && (w_count + {1'b0, r_inflight}) < 2'd2;
    wr_valid = r_state == RUN && w_count != 2'd0;
    wr_data  = wr_valid ? (r_half ? w_head[IN_W-1:OUT_W] : w_head[OUT_W-1:0]) : '0;
    busy     = r_state == RUN;
    done     = r_state == DONE;
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else r_state <= w_next;
  end

  // job length latch, word/line counters, half flag and in-flight pull marker
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_total    <= '0;
      r_pulled   <= '0;
      r_emitted  <= '0;
      r_lines    <= '0;
      r_half     <= 1'b0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= pull;
      if (w_start_ok) begin
        r_total   <= w_total;
        r_pulled  <= '0;
        r_emitted <= '0;
        r_lines   <= '0;
        r_half    <= 1'b0;
      end else begin
        if (pull) r_pulled <= r_pulled + CNT_W'(1);
        if (w_pop) r_emitted <= r_emitted + CNT_W'(1);
        if (w_accept) begin
          r_lines <= r_lines + CNT_W'(1);
          r_half  <= ~r_half;
        end
      end
    end
  end
endmodule
